// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe board constants, arbiter state encoding and square-index helpers.
// Pure declarations; no timing or flow control of its own.
package tictactoe_pkg;

  localparam int NUM_SQUARES = 9;
  localparam int BOARD_DIM   = 3;

  localparam logic [NUM_SQUARES-1:0] SQ_LSB = {{(NUM_SQUARES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  function automatic logic [3:0] onehot_to_idx(input logic [NUM_SQUARES-1:0] sq);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_SQUARES; i++) begin
      if (sq[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_SQUARES-1:0] idx_to_onehot(input logic [3:0] idx);
    return SQ_LSB << idx;
  endfunction

  function automatic logic is_onehot9(input logic [NUM_SQUARES-1:0] sq);
    return (sq != '0) && ((sq & (sq - SQ_LSB)) == '0);
  endfunction

endpackage

// File: rtl/cursor_nav.sv
// 3x3 board cursor: one wrapped step per cycle (up > down > left > right), or a direct load.
// Result visible the cycle after the pulse; never stalls.
module cursor_nav
  import tictactoe_pkg::*;
#(
  parameter logic [3:0] CURSOR_INIT = 4'd4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_load_vld,
  input  logic [3:0] i_load_idx,
  output logic [3:0] o_cursor
);

  localparam logic [3:0] DIM      = 4'(BOARD_DIM);
  localparam logic [3:0] LAST_COL = 4'(BOARD_DIM - 1);
  localparam logic [3:0] ROW_SPAN = 4'(BOARD_DIM * (BOARD_DIM - 1));

  logic [3:0] r_cursor;
  logic [3:0] w_next;
  logic [3:0] w_col;
  logic       w_top_row;
  logic       w_bot_row;

  assign w_col     = r_cursor % DIM;
  assign w_top_row = (r_cursor < DIM);
  assign w_bot_row = (r_cursor >= ROW_SPAN);

  // Vertical wraps jump a whole column span; horizontal wraps stay inside the row.
  always_comb begin
    w_next = r_cursor;
    if (i_load_vld)    w_next = i_load_idx;
    else if (i_up)     w_next = w_top_row ? r_cursor + ROW_SPAN : r_cursor - DIM;
    else if (i_down)   w_next = w_bot_row ? r_cursor - ROW_SPAN : r_cursor + DIM;
    else if (i_left)   w_next = (w_col == 4'd0) ? r_cursor + LAST_COL : r_cursor - 4'd1;
    else if (i_right)  w_next = (w_col == LAST_COL) ? r_cursor - LAST_COL : r_cursor + 4'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cursor <= CURSOR_INIT;
    else          r_cursor <= w_next;
  end

  assign o_cursor = r_cursor;

endmodule

// File: rtl/move_input_arbiter.sv
// Shares the game FSM square-select bus between mouse and keypad: a move in cycle N drives
// cuadro in N+1..N+HOLD_CYCLES, then zero for GAP_CYCLES; requests while busy are dropped.
module move_input_arbiter
  import tictactoe_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CURSOR_INIT = 4
) (
  input  logic                   clk_100MHz,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   mouse_valid,
  input  logic [NUM_SQUARES-1:0] mouse_sq,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_sel,
  output logic [NUM_SQUARES-1:0] cuadro,
  output logic [3:0]             cursor,
  output logic                   busy,
  output logic                   src_mouse,
  output logic [7:0]             drop_count
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  arb_state_t             r_state, w_state_nxt;
  logic [7:0]             r_cnt, w_cnt_nxt;
  logic [NUM_SQUARES-1:0] r_cuadro, w_cuadro_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_src_mouse, w_src_nxt;
  logic [7:0]             r_drop_count, w_drop_nxt;
  logic [1:0]             w_drop_inc;
  logic [8:0]             w_drop_sum;
  logic [3:0]             w_cursor;

  logic w_mouse_ok, w_mouse_req, w_mouse_bad, w_key_req;
  logic w_idle_live, w_grant_mouse, w_grant_key, w_grant;

  assign w_mouse_ok  = is_onehot9(mouse_sq);
  assign w_mouse_req = mouse_valid & w_mouse_ok;
  assign w_mouse_bad = mouse_valid & ~w_mouse_ok;
  assign w_key_req   = btn_sel;

  // On a tie the source that did not win last time is served.
  assign w_idle_live   = (r_state == ST_IDLE) & enable;
  assign w_grant_mouse = w_idle_live & w_mouse_req & (~w_key_req | ~r_src_mouse);
  assign w_grant_key   = w_idle_live & w_key_req & (~w_mouse_req | r_src_mouse);
  assign w_grant       = w_grant_mouse | w_grant_key;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_state_nxt = ST_DRIVE;
      ST_DRIVE: if (!enable || r_cnt == 8'd0) w_state_nxt = ST_GAP;
      ST_GAP:   if (r_cnt == 8'd0) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cuadro_nxt = r_cuadro;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_src_nxt    = r_src_mouse;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_cuadro_nxt = w_grant_mouse ? mouse_sq : idx_to_onehot(w_cursor);
          w_cnt_nxt    = HOLD_LOAD;
          w_busy_nxt   = 1'b1;
          w_src_nxt    = w_grant_mouse;
        end
      end
      ST_DRIVE: begin
        if (!enable || r_cnt == 8'd0) begin
          w_cuadro_nxt = '0;
          w_cnt_nxt    = GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == 8'd0) w_busy_nxt = 1'b0;
        else               w_cnt_nxt  = r_cnt - 8'd1;
      end
      default: begin
        w_cuadro_nxt = '0;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  // Up to two drops per cycle (bad/blocked mouse plus blocked key).
  always_comb begin
    w_drop_inc = 2'd0;
    if (r_state != ST_IDLE) w_drop_inc = {1'b0, mouse_valid} + {1'b0, w_key_req};
    else if (enable)        w_drop_inc = {1'b0, w_mouse_bad} + {1'b0, w_mouse_req & w_key_req};
  end

  assign w_drop_sum = {1'b0, r_drop_count} + {7'd0, w_drop_inc};
  assign w_drop_nxt = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_cuadro     <= '0;
      r_busy       <= 1'b0;
      r_src_mouse  <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_cuadro     <= w_cuadro_nxt;
      r_busy       <= w_busy_nxt;
      r_src_mouse  <= w_src_nxt;
      r_drop_count <= w_drop_nxt;
    end
  end

  cursor_nav #(
    .CURSOR_INIT (4'(CURSOR_INIT))
  ) u_cursor_nav (
    .i_clk      (clk_100MHz),
    .i_rst_n    (rst_n),
    .i_up       (btn_up),
    .i_down     (btn_down),
    .i_left     (btn_left),
    .i_right    (btn_right),
    .i_load_vld (w_grant_mouse),
    .i_load_idx (onehot_to_idx(mouse_sq)),
    .o_cursor   (w_cursor)
  );

  assign cuadro     = r_cuadro;
  assign cursor     = w_cursor;
  assign busy       = r_busy;
  assign src_mouse  = r_src_mouse;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_move_input_arbiter.sv
// Directed scenarios plus a randomized run against a timeline-based reference model.
module tb_move_input_arbiter;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic       clk_100MHz = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       mouse_valid;
  logic [8:0] mouse_sq;
  logic       btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [8:0] cuadro;
  logic [3:0] cursor;
  logic       busy;
  logic       src_mouse;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;

  // Reference model: a move is a window of cycle numbers rather than a state machine.
  int         cyc, grant_cyc, drv_end, gap_end, m_row, m_col, m_drops;
  logic [8:0] m_sq;
  logic       m_src;

  always #5 clk_100MHz = ~clk_100MHz;

  move_input_arbiter #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .CURSOR_INIT (4)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .rst_n       (rst_n),
    .enable      (enable),
    .mouse_valid (mouse_valid),
    .mouse_sq    (mouse_sq),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_sel     (btn_sel),
    .cuadro      (cuadro),
    .cursor      (cursor),
    .busy        (busy),
    .src_mouse   (src_mouse),
    .drop_count  (drop_count)
  );

  task automatic clear_pulses();
    mouse_valid = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_sel = 1'b0;
  endtask

  task automatic model_reset();
    cyc = 0; grant_cyc = -100; drv_end = -100; gap_end = -100;
    m_row = 1; m_col = 1; m_drops = 0; m_sq = '0; m_src = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b1; mouse_sq = '0;
    clear_pulses();
    repeat (2) @(posedge clk_100MHz);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Advance the model by the inputs of this cycle, clock the DUT, then clear pulse inputs.
  task automatic tick();
    bit bad, mreq, kreq, idle, in_drive, g_m, g_k;
    int idx;
    in_drive = (cyc > grant_cyc) && (cyc <= drv_end);
    idle     = (cyc > gap_end);
    bad      = mouse_valid && ($countones(mouse_sq) != 1);
    mreq     = mouse_valid && !bad;
    kreq     = btn_sel;
    g_m = 0; g_k = 0;
    if (idle) begin
      if (enable) begin
        if (bad) m_drops++;
        if (mreq && kreq) begin
          m_drops++;
          g_m = !m_src;
          g_k = m_src;
        end else begin
          g_m = mreq;
          g_k = kreq;
        end
      end
    end else begin
      m_drops += (mouse_valid ? 1 : 0) + (kreq ? 1 : 0);
      if (in_drive && !enable) begin
        drv_end = cyc;
        gap_end = cyc + GAP;
      end
    end
    if (m_drops > 255) m_drops = 255;
    if (g_m || g_k) begin
      grant_cyc = cyc;
      drv_end   = cyc + HOLD;
      gap_end   = drv_end + GAP;
      m_src     = g_m;
      m_sq      = g_m ? mouse_sq : 9'(1 << (m_row * 3 + m_col));
    end
    if (g_m) begin
      idx = 0;
      for (int i = 0; i < 9; i++) if (mouse_sq[i]) idx = i;
      m_row = idx / 3;
      m_col = idx % 3;
    end else if (btn_up)    m_row = (m_row + 2) % 3;
    else if (btn_down)      m_row = (m_row + 1) % 3;
    else if (btn_left)      m_col = (m_col + 2) % 3;
    else if (btn_right)     m_col = (m_col + 1) % 3;
    @(posedge clk_100MHz);
    #1;
    cyc++;
    clear_pulses();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cuadro !== 9'd0)     begin errors++; $display("FAIL reset_cuadro: got %b want 0", cuadro); end
    checks++; if (cursor !== 4'd4)     begin errors++; $display("FAIL reset_cursor: got %0d want 4", cursor); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (src_mouse !== 1'b0)  begin errors++; $display("FAIL reset_src: got %b want 0", src_mouse); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drops: got %0d want 0", drop_count); end
  endtask

  task automatic test_cursor_wrap();
    do_reset();
    btn_right = 1'b1; tick();
    checks++; if (cursor !== 4'd5) begin errors++; $display("FAIL cursor_right1: got %0d want 5", cursor); end
    btn_right = 1'b1; tick();
    checks++; if (cursor !== 4'd3) begin errors++; $display("FAIL cursor_right_wrap: got %0d want 3", cursor); end
    btn_up = 1'b1; tick();
    checks++; if (cursor !== 4'd0) begin errors++; $display("FAIL cursor_up1: got %0d want 0", cursor); end
    btn_up = 1'b1; tick();
    checks++; if (cursor !== 4'd6) begin errors++; $display("FAIL cursor_up_wrap: got %0d want 6", cursor); end
    do_reset();
    btn_up = 1'b1; btn_left = 1'b1; tick();
    checks++; if (cursor !== 4'd1) begin errors++; $display("FAIL cursor_up_prio: got %0d want 1", cursor); end
  endtask

  task automatic test_mouse_grant();
    do_reset();
    mouse_valid = 1'b1; mouse_sq = 9'b000000100; tick();
    checks++; if (cursor !== 4'd2)    begin errors++; $display("FAIL mouse_cursor: got %0d want 2", cursor); end
    checks++; if (src_mouse !== 1'b1) begin errors++; $display("FAIL mouse_src: got %b want 1", src_mouse); end
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (cuadro !== ((k <= HOLD) ? 9'b000000100 : 9'd0)) begin
        errors++; $display("FAIL mouse_cuadro N+%0d: got %b", k, cuadro);
      end
      checks++;
      if (busy !== (k <= HOLD + GAP)) begin
        errors++; $display("FAIL mouse_busy N+%0d: got %b", k, busy);
      end
      if (k < 7) tick();
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    mouse_valid = 1'b1; mouse_sq = 9'b000000001; btn_sel = 1'b1; tick();
    checks++; if (cuadro !== 9'b000000001) begin errors++; $display("FAIL simul1_cuadro: got %b want 000000001", cuadro); end
    checks++; if (src_mouse !== 1'b1)      begin errors++; $display("FAIL simul1_src: got %b want 1", src_mouse); end
    checks++; if (drop_count !== 8'd1)     begin errors++; $display("FAIL simul1_drops: got %0d want 1", drop_count); end
    repeat (6) tick();
    mouse_valid = 1'b1; mouse_sq = 9'b000000001; btn_sel = 1'b1; tick();
    checks++; if (cuadro !== 9'b000000001) begin errors++; $display("FAIL simul2_cuadro: got %b want 000000001", cuadro); end
    checks++; if (src_mouse !== 1'b0)      begin errors++; $display("FAIL simul2_src: got %b want 0", src_mouse); end
    checks++; if (drop_count !== 8'd2)     begin errors++; $display("FAIL simul2_drops: got %0d want 2", drop_count); end
    checks++; if (busy !== 1'b1)           begin errors++; $display("FAIL simul2_busy: got %b want 1", busy); end
  endtask

  task automatic test_busy_drop();
    do_reset();
    btn_sel = 1'b1; tick();
    tick();
    btn_sel = 1'b1; tick();
    checks++; if (cuadro !== 9'b000010000) begin errors++; $display("FAIL busy_drop_cuadro: got %b want 000010000", cuadro); end
    checks++; if (drop_count !== 8'd1)     begin errors++; $display("FAIL busy_drop_count: got %0d want 1", drop_count); end
    mouse_sq = 9'b000000011;
    repeat (300) begin
      mouse_valid = 1'b1; tick();
    end
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d want 255", drop_count); end
    mouse_valid = 1'b1; btn_sel = 1'b1; tick();
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_nowrap: got %0d want 255", drop_count); end
  endtask

  task automatic test_invalid_disabled();
    do_reset();
    mouse_valid = 1'b1; mouse_sq = 9'b000000011; tick();
    checks++; if (cuadro !== 9'd0)     begin errors++; $display("FAIL invalid_cuadro: got %b want 0", cuadro); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL invalid_busy: got %b want 0", busy); end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL invalid_drops: got %0d want 1", drop_count); end
    enable = 1'b0; btn_sel = 1'b1; tick();
    checks++; if (cuadro !== 9'd0)     begin errors++; $display("FAIL disabled_cuadro: got %b want 0", cuadro); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL disabled_busy: got %b want 0", busy); end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL disabled_drops: got %0d want 1", drop_count); end
    enable = 1'b1;
  endtask

  task automatic test_abort();
    do_reset();
    btn_sel = 1'b1; tick();
    tick();
    enable = 1'b0; tick();
    checks++; if (cuadro !== 9'd0) begin errors++; $display("FAIL abort_cuadro: got %b want 0", cuadro); end
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL abort_gap1_busy: got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL abort_gap2_busy: got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL abort_idle_busy: got %b want 0", busy); end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    mouse_valid = 1'b1; mouse_sq = 9'b000000110; tick();
    btn_right = 1'b1; tick();
    btn_sel = 1'b1; tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cuadro !== 9'd0)     begin errors++; $display("FAIL areset_cuadro: got %b want 0", cuadro); end
    checks++; if (cursor !== 4'd4)     begin errors++; $display("FAIL areset_cursor: got %0d want 4", cursor); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL areset_drops: got %0d want 0", drop_count); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [8:0] exp_cuadro;
    logic       exp_busy;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      enable      = ($urandom_range(0, 11) != 0);
      mouse_valid = ($urandom_range(0, 5) == 0);
      mouse_sq    = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'(1 << $urandom_range(0, 8));
      btn_sel     = ($urandom_range(0, 5) == 0);
      btn_up      = ($urandom_range(0, 4) == 0);
      btn_down    = ($urandom_range(0, 4) == 0);
      btn_left    = ($urandom_range(0, 4) == 0);
      btn_right   = ($urandom_range(0, 4) == 0);
      tick();
      exp_cuadro = ((cyc > grant_cyc) && (cyc <= drv_end)) ? m_sq : 9'd0;
      exp_busy   = (cyc > grant_cyc) && (cyc <= gap_end);
      checks++; if (cuadro !== exp_cuadro) begin errors++; $display("FAIL rand_cuadro c%0d: got %b want %b", cyc, cuadro, exp_cuadro); end
      checks++; if (busy !== exp_busy)     begin errors++; $display("FAIL rand_busy c%0d: got %b want %b", cyc, busy, exp_busy); end
      checks++; if (cursor !== 4'(m_row * 3 + m_col)) begin errors++; $display("FAIL rand_cursor c%0d: got %0d want %0d", cyc, cursor, m_row * 3 + m_col); end
      checks++; if (src_mouse !== m_src)   begin errors++; $display("FAIL rand_src c%0d: got %b want %b", cyc, src_mouse, m_src); end
      checks++; if (drop_count !== 8'(m_drops)) begin errors++; $display("FAIL rand_drops c%0d: got %0d want %0d", cyc, drop_count, m_drops); end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; mouse_sq = '0;
    clear_pulses();
    model_reset();
    test_reset();
    test_cursor_wrap();
    test_mouse_grant();
    test_simultaneous();
    test_busy_drop();
    test_invalid_disabled();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_input_arbiter.md
Name: move_input_arbiter

Overview:
- Shares the single one-hot square-select bus (cuadro) of the tic-tac-toe game FSM between two move sources: mouse clicks and a push-button cursor (up/down/left/right/select).
- Arbitrates simultaneous requests, maintains the 3x3 cursor, and holds each granted move for a fixed window so the game FSM completes its check-position/assign/check-winner sequence.
- Then forces cuadro to zero so the game FSM returns to its waiting state.
- Sits between the input conditioners (mouse decoder, button debouncers) and the game FSM.

Parameters:
- HOLD_CYCLES, 4: cycles cuadro stays asserted per granted move; legal range 3..255.
- GAP_CYCLES, 2: cycles cuadro is forced to zero after a move; legal range 1..255.
- CURSOR_INIT, 4: cursor index after reset (centre square).

Ports:
- clk_100MHz  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  game FSM accepts moves (low while a winner or draw is displayed)
- mouse_valid  in  1  single-cycle pulse: mouse click on the board
- mouse_sq  in  9  one-hot square under the mouse, sampled when mouse_valid=1
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced single-cycle pulses
- btn_sel  in  1  debounced single-cycle pulse: play the square under the cursor
- cuadro  out  9  one-hot square select to the game FSM
- cursor  out  4  cursor index 0..8 (row = idx/3, col = idx%3), for display
- busy  out  1  high while in DRIVE or GAP
- src_mouse  out  1  source of the last grant (1 = mouse, 0 = keys)
- drop_count  out  8  saturating count of dropped requests

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous): cuadro=0, cursor=CURSOR_INIT, busy=0, src_mouse=0, drop_count=0, state=IDLE.
- Request validity:
  - mouse_req = mouse_valid & (mouse_sq has exactly one bit set).
  - mouse_valid with a non-one-hot mouse_sq (zero or several bits set) is ignored and counts as a drop.
  - key_req = btn_sel; it plays the square at the current cursor.
- States: IDLE, DRIVE, GAP.
- IDLE:
  - enable=0: requests are ignored and not counted.
  - enable=1 with one request: grant it, latch the one-hot square, set src_mouse, load the counter with HOLD_CYCLES-1, go to DRIVE.
  - Both requests in the same cycle: round-robin. Grant the source that is not src_mouse; drop the other (drop_count+1).
- Latency: a request in cycle N drives cuadro = latched square in cycles N+1 .. N+HOLD_CYCLES.
- DRIVE:
  - cuadro holds the latched square; busy=1; the counter decrements.
  - When the counter reaches 0: cuadro=0, load GAP_CYCLES-1, go to GAP.
  - enable falling during DRIVE aborts the move: cuadro=0 from the next cycle, go to GAP.
- GAP:
  - cuadro=0, busy=1. When the counter reaches 0, go to IDLE; busy=0 from the next cycle.
- Any request arriving in DRIVE or GAP is dropped and counts as a drop.
- drop_count saturates at 255 and never wraps.
- Cursor (updated in every state, one step per cycle):
  - Direction priority when several pulses arrive together: up > down > left > right; only the winner is applied.
  - up: row-1, wrapping 0->2. down: row+1, wrapping 2->0.
  - left: col-1, wrapping 0->2 within the row. right: col+1, wrapping 2->0 within the row.
  - A granted mouse move sets cursor to the index of mouse_sq. This overrides a direction pulse in the same cycle.
- The block does not check square occupancy; the game FSM rejects occupied squares.

Decomposition:
- Shared package/include tictactoe_pkg:
  - NUM_SQUARES=9 and BOARD_DIM=3.
  - Arbiter state encodings.
  - onehot_to_idx and idx_to_onehot functions.
  - is_onehot9 function.
- One sub-module, cursor_nav: 3x3 cursor register with wrap and direction priority, plus a load port used for mouse grants.

Test Plan:
- Cursor wrap: after reset cursor=4; btn_right -> 5; btn_right -> 3; btn_up x2 from 3 -> 0 then 6; btn_up+btn_left in the same cycle from 4 -> 1 (up wins).
- Mouse grant: mouse_valid, mouse_sq=9'b000000100, enable=1 in cycle N:
  - cuadro=9'b000000100 in cycles N+1..N+4, then 0 in N+5..N+6.
  - busy=1 in N+1..N+6, 0 in N+7.
  - cursor=2, src_mouse=1.
- Simultaneous requests:
  - First case: right after reset, cursor=4; mouse_sq=9'b000000001 and btn_sel together -> mouse granted (cuadro=9'b000000001), drop_count=1.
  - Second case: after GAP, the same simultaneous pair -> keys granted (cuadro=9'b000000001, the cursor index after the first grant), src_mouse=0, drop_count=2.
- Busy drop: btn_sel in the 2nd DRIVE cycle -> cuadro unchanged, drop_count+1. Driving 300 such drops -> drop_count=255.
- Invalid and disabled input:
  - mouse_sq=9'b000000011 with mouse_valid -> cuadro stays 0, drop_count+1.
  - enable=0 with btn_sel -> no grant, drop_count unchanged.
- Abort and reset:
  - enable falls in the 2nd DRIVE cycle -> cuadro=0 next cycle, GAP_CYCLES of busy, then IDLE.
  - rst_n low mid-DRIVE -> cuadro=0, cursor=4, drop_count=0 immediately (no clock edge required).
